// File: rtl/io_switch_port.sv
// Memory-mapped switch/pushbutton input port for the 16-bit MIPS data bus.
// Synchronises and debounces SW0/SW1/PB0, latches a read-cleared press flag.
module io_switch_port #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          CNT_WIDTH       = 16,
  parameter logic [15:0] PORT_ADDR       = 16'hfff0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sw0_raw,
  input  logic        sw1_raw,
  input  logic        pb0_raw,
  input  logic [15:0] addr,
  input  logic        read,
  output logic [15:0] rdata,
  output logic        io_sw0,
  output logic        io_sw1,
  output logic        pb_pressed
);

  localparam logic [15:0] CNT_ADDR = PORT_ADDR + 16'd2;
  localparam logic [CNT_WIDTH-1:0] LIMIT =
    CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  // bit 0 = SW0, bit 1 = SW1, bit 2 = PB0
  logic [2:0] raw;
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic [2:0] stable_q, stable_d;
  logic [2:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic       pressed_q, pressed_d;
  logic [7:0] count_q, count_d;
  logic       rise;
  logic       clr;

  assign raw = {pb0_raw, sw1_raw, sw0_raw};

  // two-flop synchroniser chain
  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
  end

  // per-input debounce: adopt a new level after DEBOUNCE_CYCLES differing cycles
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] + ONE == LIMIT) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
  end

  // press flag and counter; a press on the same edge as a clearing read wins
  always_comb begin
    rise      = stable_d[2] & ~stable_q[2];
    clr       = read && (addr == PORT_ADDR);
    pressed_d = pressed_q;
    count_d   = count_q;
    if (rise) begin
      pressed_d = 1'b1;
      count_d   = count_q + 8'd1;
    end else if (clr) begin
      pressed_d = 1'b0;
    end
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q    <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
    end
  end

  // read mux; the port drives zero unless one of its words is selected
  always_comb begin
    rdata = 16'd0;
    if (read) begin
      if (addr == PORT_ADDR)
        rdata = {13'd0, stable_q[1], stable_q[0], pressed_q};
      else if (addr == CNT_ADDR)
        rdata = {8'd0, count_q};
    end
  end

  assign io_sw0     = stable_q[0];
  assign io_sw1     = stable_q[1];
  assign pb_pressed = pressed_q;

endmodule

// File: tb/tb_io_switch_port.sv
// Bench for io_switch_port: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the port.
module tb_io_switch_port;

  localparam int          DB = 4;
  localparam logic [15:0] P  = 16'hfff0;
  localparam logic [15:0] P2 = 16'hfff2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sw0_raw = 1'b0;
  logic        sw1_raw = 1'b0;
  logic        pb0_raw = 1'b0;
  logic [15:0] addr = 16'd0;
  logic        read = 1'b0;
  logic [15:0] rdata;
  logic        io_sw0;
  logic        io_sw1;
  logic        pb_pressed;

  int n_pass = 0;
  int n_tot  = 0;

  io_switch_port #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(16),
    .PORT_ADDR(P)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw0_raw(sw0_raw),
    .sw1_raw(sw1_raw),
    .pb0_raw(pb0_raw),
    .addr(addr),
    .read(read),
    .rdata(rdata),
    .io_sw0(io_sw0),
    .io_sw1(io_sw1),
    .pb_pressed(pb_pressed)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // behavioural model: raw history, run lengths of disagreement
  logic [2:0] rawq[$];
  logic [2:0] m_stable = '0;
  int         m_run[3] = '{0, 0, 0};
  logic       m_press = 1'b0;
  int         m_count = 0;
  logic [2:0] m_syn;
  logic       m_prev_pb;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rawq.delete();
      m_stable = '0;
      m_run    = '{0, 0, 0};
      m_press  = 1'b0;
      m_count  = 0;
    end else begin
      m_syn = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 3'b000;
      rawq.push_back({pb0_raw, sw1_raw, sw0_raw});
      if (rawq.size() > 2) void'(rawq.pop_front());
      m_prev_pb = m_stable[2];
      for (int i = 0; i < 3; i++) begin
        if (m_syn[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] >= DB) begin
            m_stable[i] = m_syn[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (!m_prev_pb && m_stable[2]) begin
        m_press = 1'b1;
        m_count = (m_count + 1) % 256;
      end else if (read && addr == P) begin
        m_press = 1'b0;
      end
    end
  end

  function automatic logic [15:0] exp_rdata();
    if (!read) return 16'd0;
    if (addr == P) return {13'd0, m_stable[1], m_stable[0], m_press};
    if (addr == P2) return 16'(m_count);
    return 16'd0;
  endfunction

  // every-cycle comparison against the model
  always @(posedge clock) begin
    #1;
    check("cmp_sw0", {15'd0, io_sw0}, {15'd0, m_stable[0]});
    check("cmp_sw1", {15'd0, io_sw1}, {15'd0, m_stable[1]});
    check("cmp_pb", {15'd0, pb_pressed}, {15'd0, m_press});
    check("cmp_rdata", rdata, exp_rdata());
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic watch_sw1(input int n);
    repeat (n) begin
      @(negedge clock);
      check("sw1_glitch", {15'd0, io_sw1}, 16'd0);
    end
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clock);
    #1;
    check("rst_sw0", {15'd0, io_sw0}, 16'd0);
    check("rst_pb", {15'd0, pb_pressed}, 16'd0);
    reset = 1'b1;
    read = 1'b1; addr = P;
    #1 check("rst_rd_stat", rdata, 16'h0000);
    addr = P2;
    #1 check("rst_rd_cnt", rdata, 16'h0000);
    read = 1'b0;
    cyc(2);

    // clean SW0 change: rises on the 6th edge
    sw0_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock);
      #1 check("sw0_lat", {15'd0, io_sw0}, (i == 6) ? 16'd1 : 16'd0);
    end
    @(negedge clock);
    read = 1'b1; addr = P;
    #1 check("rd_sw0", rdata, 16'h0002);
    read = 1'b0;
    sw1_raw = 1'b1;
    cyc(8);
    read = 1'b1; addr = P;
    #1 check("rd_sw01", rdata, 16'h0006);
    read = 1'b0;

    // glitch rejection on SW1
    sw1_raw = 1'b0;
    sw0_raw = 1'b0;
    cyc(10);
    sw1_raw = 1'b1;
    watch_sw1(3);
    sw1_raw = 1'b0;
    watch_sw1(2);
    for (int i = 0; i < 8; i++) begin
      sw1_raw = ~sw1_raw;
      watch_sw1(1);
    end
    sw1_raw = 1'b0;
    watch_sw1(6);

    // bouncy pushbutton: exactly one press
    for (int i = 0; i < 5; i++) begin
      pb0_raw = (i % 2 == 0);
      cyc(1);
    end
    pb0_raw = 1'b1;
    cyc(10);
    pb0_raw = 1'b0;
    cyc(8);
    check("pb_flag", {15'd0, pb_pressed}, 16'd1);
    read = 1'b1; addr = P;
    #1 check("rd_press", rdata, 16'h0001);
    cyc(1);
    #1 check("rd_cleared", rdata, 16'h0000);
    addr = P2;
    #1 check("rd_cnt1", rdata, 16'h0001);
    read = 1'b0;

    // press edge coincides with clearing read
    cyc(2);
    pb0_raw = 1'b1;
    cyc(5);
    read = 1'b1; addr = P;
    @(posedge clock);
    #1 check("same_edge_pb", {15'd0, pb_pressed}, 16'd1);
    @(negedge clock);
    addr = P2;
    #1 check("same_edge_cnt", rdata, 16'h0002);
    read = 1'b0;
    pb0_raw = 1'b0;
    cyc(8);

    // wrap: 256 presses in total since reset
    repeat (254) begin
      pb0_raw = 1'b1;
      cyc(7);
      pb0_raw = 1'b0;
      cyc(7);
    end
    read = 1'b1; addr = P2;
    #1 check("cnt_wrap", rdata, 16'h0000);
    read = 1'b0;

    // random stimulus, checked by the model every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      if ($urandom_range(5) == 0) sw0_raw = ~sw0_raw;
      if ($urandom_range(5) == 0) sw1_raw = ~sw1_raw;
      if ($urandom_range(3) == 0) pb0_raw = ~pb0_raw;
      read = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: addr = P;
        1: addr = P2;
        2: addr = 16'($urandom);
        default: addr = P - 16'd2;
      endcase
    end

    // asynchronous reset mid-debounce
    @(negedge clock);
    read = 1'b0; sw0_raw = 1'b0; sw1_raw = 1'b0; pb0_raw = 1'b1;
    cyc(10);
    pb0_raw = 1'b0;
    cyc(8);
    read = 1'b1; addr = P2;
    sw0_raw = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_sw0", {15'd0, io_sw0}, 16'd0);
    check("arst_pb", {15'd0, pb_pressed}, 16'd0);
    check("arst_cnt", rdata, 16'h0000);
    cyc(2);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock);
      #1 check("arst_relat", {15'd0, io_sw0}, (i == 6) ? 16'd1 : 16'd0);
    end
    read = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
